uimx_415_reg_check: RTL

// Read-back verifier for the IMX415 configuration table. After the config writer finishes,
// it walks the same register LUT (16-bit address, 8-bit value per entry) and reads each

---
 rtl/uimx_415_reg_check.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uimx_415_reg_check.sv
// uimx_415_reg_check
// Read-back verifier for the IMX415 register table. It walks the shared LUT
// and reads every non-volatile address back through the sensor I2C master.
// Each returned byte is compared with the table value. The block reports
// pass/fail, the error count and details of the first failing entry.
module uimx_415_reg_check #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter logic [15:0] SKIP_ADDR0  = 16'h3000,
  parameter logic [15:0] SKIP_ADDR1  = 16'h3002
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic        I_start,
  input  logic        I_abort,
  output logic [8:0]  O_reg_index,
  input  logic [31:0] I_reg_data,
  input  logic [7:0]  I_reg_size,
  output logic        O_rd_req,
  output logic [15:0] O_rd_addr,
  input  logic        I_rd_ack,
  input  logic        I_rd_done,
  input  logic [7:0]  I_rd_data,
  input  logic        I_rd_err,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_pass,
  output logic [7:0]  O_err_cnt,
  output logic [7:0]  O_skip_cnt,
  output logic [8:0]  O_first_err_idx,
  output logic [7:0]  O_first_err_got,
  output logic [7:0]  O_first_err_exp
);

  // Timeout counter width; kept at least one bit for tiny test values.
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CMP   = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t        state_r;
  logic [7:0]    exp_r;
  logic [7:0]    got_r;
  logic          rd_err_r;
  logic [TW-1:0] tmo_r;

  logic          fetch_skip_s;
  logic          err_hit_s;
  logic [7:0]    err_got_s;
  logic          last_entry_s;
  logic          unused_s;

  // The LUT top byte carries no information for this block.
  assign unused_s = ^I_reg_data[31:24];

  // Classify the current LUT entry and detect the final entry of the pass.
  always_comb begin
    fetch_skip_s = 1'b0;
    last_entry_s = 1'b0;
    if ((I_reg_data[23:8] == SKIP_ADDR0) || (I_reg_data[23:8] == SKIP_ADDR1) ||
        (I_reg_data[23:8] == 16'h0000)) begin
      fetch_skip_s = 1'b1;
    end else begin
      fetch_skip_s = 1'b0;
    end
    // 9-bit compare so the index never wraps past a 255-entry table.
    if ((O_reg_index + 9'd1) == {1'b0, I_reg_size}) begin
      last_entry_s = 1'b1;
    end else begin
      last_entry_s = 1'b0;
    end
  end

  // Decide whether this cycle records an error, and which byte it reports.
  always_comb begin
    err_hit_s = 1'b0;
    err_got_s = 8'h00;
    case (state_r)
      ST_WAIT: begin
        // A completion arriving on the timeout cycle takes precedence.
        if (!I_rd_done && (tmo_r == TMO_LAST)) begin
          err_hit_s = 1'b1;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      ST_CMP: begin
        if (rd_err_r) begin
          err_hit_s = 1'b1;
          err_got_s = 8'h00;
        end else if (got_r != exp_r) begin
          err_hit_s = 1'b1;
          err_got_s = got_r;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      default: begin
        err_hit_s = 1'b0;
        err_got_s = 8'h00;
      end
    endcase
  end

  // Main sequencer: walks the LUT, drives the read handshake, keeps results.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_r         <= ST_IDLE;
      exp_r           <= 8'h00;
      got_r           <= 8'h00;
      rd_err_r        <= 1'b0;
      tmo_r           <= '0;
      O_reg_index     <= 9'd0;
      O_rd_req        <= 1'b0;
      O_rd_addr       <= 16'h0000;
      O_busy          <= 1'b0;
      O_done          <= 1'b0;
      O_pass          <= 1'b0;
      O_err_cnt       <= 8'd0;
      O_skip_cnt      <= 8'd0;
      O_first_err_idx <= 9'd0;
      O_first_err_got <= 8'h00;
      O_first_err_exp <= 8'h00;
    end else if (I_abort) begin
      // Abandon the pass; results so far are kept and no done pulse is given.
      state_r  <= ST_IDLE;
      O_rd_req <= 1'b0;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
    end else begin
      O_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (I_start) begin
            O_reg_index     <= 9'd0;
            O_pass          <= 1'b0;
            O_err_cnt       <= 8'd0;
            O_skip_cnt      <= 8'd0;
            O_first_err_idx <= 9'd0;
            O_first_err_got <= 8'h00;
            O_first_err_exp <= 8'h00;
            O_busy          <= 1'b1;
            state_r         <= (I_reg_size == 8'd0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_skip_s) begin
            O_skip_cnt <= O_skip_cnt + 8'd1;
            state_r    <= ST_NEXT;
          end else begin
            O_rd_addr <= I_reg_data[23:8];
            exp_r     <= I_reg_data[7:0];
            O_rd_req  <= 1'b1;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (I_rd_ack) begin
            O_rd_req <= 1'b0;
            tmo_r    <= '0;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (I_rd_done) begin
            got_r    <= I_rd_data;
            rd_err_r <= I_rd_err;
            state_r  <= ST_CMP;
          end else if (tmo_r == TMO_LAST) begin
            state_r <= ST_NEXT;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        ST_CMP: begin
          state_r <= ST_NEXT;
        end
        ST_NEXT: begin
          if (last_entry_s) begin
            state_r <= ST_DONE;
          end else begin
            O_reg_index <= O_reg_index + 9'd1;
            state_r     <= ST_FETCH;
          end
        end
        ST_DONE: begin
          O_done  <= 1'b1;
          O_pass  <= (O_err_cnt == 8'd0);
          O_busy  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          O_rd_req <= 1'b0;
          O_busy   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase

      // Error bookkeeping; a zero count means this is the first failure.
      if (err_hit_s) begin
        if (O_err_cnt != 8'hFF) begin
          O_err_cnt <= O_err_cnt + 8'd1;
        end
        if (O_err_cnt == 8'd0) begin
          O_first_err_idx <= O_reg_index;
          O_first_err_got <= err_got_s;
          O_first_err_exp <= exp_r;
        end
      end
    end
  end

endmodule
